usb_tx_packet_builder: RTL and testbench

- Parametrised successor to the fixed 64-byte TX packet compiler.
- Assembles a complete USB packet into a wide parallel vector for the downstream NRZI/bit-stuff serializer: SYNC, PID, optional payload fetched byte-by-byte from the TX data buffer, and CRC16 computed on the fly.
- Handshake PIDs (SYNC+PID only) and data PIDs (SYNC+PID+payload+CRC16) are both supported, with payload depth set by parameter.
- Sits between the TX controller FSM and the TX data buffer.

---
 rtl/usb_tx_packet_builder_pkg.sv | 20 ++
 rtl/usb_crc16_byte.sv | 19 +
 rtl/usb_tx_packet_builder.sv | 118 +++++++++++
 tb/tb_usb_tx_packet_builder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_packet_builder_pkg.sv
// Shared constants and state type for the USB TX packet builder and CRC16 helpers.
package usb_tx_pkg;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    localparam logic [7:0]  SYNC_BYTE       = 8'h80;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CRC,
        S_DONE
    } tx_build_state_t;
endpackage

// File: rtl/usb_crc16_byte.sv
// One-byte step of the reflected USB CRC16; pure combinational, reused by the RX checker.
module usb_crc16_byte
    import usb_tx_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);
    always_comb begin
        crc_out = crc_in;
        // Bits enter LSB first, matching wire order.
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0] ^ data[i])
                crc_out = (crc_out >> 1) ^ CRC16_POLY_REFL;
            else
                crc_out = crc_out >> 1;
        end
    end
endmodule

// File: rtl/usb_tx_packet_builder.sv
// Builds SYNC+PID(+payload+CRC16) into a parallel vector for the NRZI/bit-stuff serializer.
module usb_tx_packet_builder
    import usb_tx_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 64,
    parameter int OCC_W          = $clog2(MAX_DATA_BYTES + 1),
    parameter int PKT_W          = 8 * (MAX_DATA_BYTES + 4),
    parameter int LEN_W          = $clog2(PKT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       pid,
    input  logic [OCC_W-1:0] occupancy,
    input  logic [7:0]       buf_rdata,
    output logic             buf_get,
    output logic             busy,
    output logic             pkt_ready,
    output logic             pkt_err,
    output logic [PKT_W-1:0] pkt_bits,
    output logic [LEN_W-1:0] pkt_len_bits
);
    localparam int SEL_W = $clog2(PKT_W);
    localparam logic [OCC_W-1:0] MAX_N = OCC_W'(MAX_DATA_BYTES);

    tx_build_state_t  state;
    logic [3:0]       pid_q;
    logic [OCC_W-1:0] n_q, get_cnt, cap_cnt;
    logic             is_data, got_d;
    logic [15:0]      crc, crc_nxt;
    logic [SEL_W-1:0] cap_lsb, crc_lsb;
    logic             pid_hs, pid_dat;

    assign pid_hs  = (pid == PID_ACK) || (pid == PID_NAK) || (pid == PID_STALL);
    assign pid_dat = (pid == PID_DATA0) || (pid == PID_DATA1);
    assign busy    = (state != S_IDLE);

    // Payload byte i lands at byte 2+i; CRC follows the last payload byte.
    assign cap_lsb = SEL_W'({cap_cnt, 3'b000}) + SEL_W'(16);
    assign crc_lsb = SEL_W'({n_q, 3'b000}) + SEL_W'(16);

    usb_crc16_byte u_crc (
        .crc_in  (crc),
        .data    (buf_rdata),
        .crc_out (crc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            pid_q        <= '0;
            n_q          <= '0;
            get_cnt      <= '0;
            cap_cnt      <= '0;
            is_data      <= 1'b0;
            got_d        <= 1'b0;
            crc          <= CRC16_INIT;
            buf_get      <= 1'b0;
            pkt_ready    <= 1'b0;
            pkt_err      <= 1'b0;
            pkt_bits     <= '0;
            pkt_len_bits <= '0;
        end else begin
            pkt_ready <= 1'b0;
            pkt_err   <= 1'b0;
            got_d     <= buf_get;
            case (state)
                S_IDLE: if (start) begin
                    pid_q   <= pid;
                    n_q     <= occupancy;
                    is_data <= pid_dat;
                    if (pid_hs || (pid_dat && occupancy <= MAX_N))
                        state <= S_HDR;
                    else
                        pkt_err <= 1'b1;
                end
                S_HDR: begin
                    pkt_bits     <= PKT_W'({~pid_q, pid_q, SYNC_BYTE});
                    pkt_len_bits <= is_data ? '0 : LEN_W'(16);
                    crc          <= CRC16_INIT;
                    get_cnt      <= '0;
                    cap_cnt      <= '0;
                    if (!is_data) begin
                        state     <= S_DONE;
                        pkt_ready <= 1'b1;
                    end else if (n_q == '0) begin
                        state <= S_CRC;
                    end else begin
                        state   <= S_DATA;
                        buf_get <= 1'b1;
                    end
                end
                S_DATA: begin
                    // Pops run one cycle ahead of captures; stop issuing at N.
                    if (buf_get) begin
                        get_cnt <= get_cnt + 1'b1;
                        buf_get <= (get_cnt + 1'b1) < n_q;
                    end
                    if (got_d) begin
                        pkt_bits[cap_lsb +: 8] <= buf_rdata;
                        crc                    <= crc_nxt;
                        cap_cnt                <= cap_cnt + 1'b1;
                        if ((cap_cnt + 1'b1) == n_q)
                            state <= S_CRC;
                    end
                end
                S_CRC: begin
                    pkt_bits[crc_lsb +: 16] <= ~crc;
                    pkt_len_bits            <= LEN_W'({n_q, 3'b000}) + LEN_W'(32);
                    state                   <= S_DONE;
                    pkt_ready               <= 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_tx_packet_builder.sv
// Randomized bench for usb_tx_packet_builder against a per-request packet model.
module tb_usb_tx_packet_builder;
    localparam int MAXB  = 64;
    localparam int OCC_W = $clog2(MAXB + 1);
    localparam int PKT_W = 8 * (MAXB + 4);
    localparam int LEN_W = $clog2(PKT_W + 1);

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [3:0] pid = '0;
    logic [OCC_W-1:0] occupancy = '0;
    logic [7:0] buf_rdata = '0;
    logic buf_get, busy, pkt_ready, pkt_err;
    logic [PKT_W-1:0] pkt_bits;
    logic [LEN_W-1:0] pkt_len_bits;

    usb_tx_packet_builder #(.MAX_DATA_BYTES(MAXB)) dut (
        .clk(clk), .rst(rst), .start(start), .pid(pid), .occupancy(occupancy),
        .buf_rdata(buf_rdata), .buf_get(buf_get), .busy(busy), .pkt_ready(pkt_ready),
        .pkt_err(pkt_err), .pkt_bits(pkt_bits), .pkt_len_bits(pkt_len_bits)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference CRC16/USB over a byte list, returned already inverted.
    function automatic logic [15:0] crc16_usb(input logic [7:0] d[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (d[k]) begin
            c = c ^ {8'h00, d[k]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [PKT_W-1:0] build_pkt(input logic [3:0] p, input logic [7:0] d[$], input bit data);
        logic [PKT_W-1:0] v;
        v = '0;
        v[7:0]  = 8'h80;
        v[15:8] = {~p, p};
        if (data) begin
            foreach (d[k]) v[8*(k+2) +: 8] = d[k];
            v[8*(d.size()+2) +: 16] = crc16_usb(d);
        end
        return v;
    endfunction

    // Buffer model: byte popped in cycle c is presented during cycle c+1.
    logic [7:0] buf_q[$];
    int gets_total = 0, err_total = 0;
    longint ready_cyc = 0;
    bit pend = 0;
    logic [7:0] pend_byte = '0;
    always @(negedge clk) begin
        if (rst) begin
            pend = 0;
        end else begin
            buf_rdata = pend ? pend_byte : 8'($urandom);
            pend = 0;
            if (buf_get) begin
                pend_byte = (buf_q.size() > 0) ? buf_q.pop_front() : 8'hEE;
                pend = 1;
                gets_total++;
            end
            if (pkt_ready) ready_cyc = cyc;
            if (pkt_err) err_total++;
        end
    end

    // Behavioural model + per-cycle compare.
    bit act = 0;
    longint s_cyc = 0, err_cyc = -100;
    int L = 0, N = 0;
    logic [PKT_W-1:0] exp_bits = '0, held_bits = '0;
    logic [LEN_W-1:0] exp_len = '0, held_len = '0;
    always @(negedge clk) begin
        bit eb, eg, er, ee;
        logic [7:0] pl[$];
        if (rst) begin
            chk("rst_ctl", PKT_W'({busy, buf_get, pkt_ready, pkt_err}), '0);
            chk("rst_bits", pkt_bits, '0);
            chk("rst_len", PKT_W'(pkt_len_bits), '0);
            act = 0; held_bits = '0; held_len = '0; err_cyc = -100;
        end else begin
            eb = act && cyc >= s_cyc + 1 && cyc <= s_cyc + L;
            eg = act && cyc >= s_cyc + 2 && cyc <= s_cyc + 1 + N;
            er = act && cyc == s_cyc + L;
            ee = (cyc == err_cyc);
            chk("busy", PKT_W'(busy), PKT_W'(eb));
            chk("buf_get", PKT_W'(buf_get), PKT_W'(eg));
            chk("pkt_ready", PKT_W'(pkt_ready), PKT_W'(er));
            chk("pkt_err", PKT_W'(pkt_err), PKT_W'(ee));
            if (er) begin
                chk("pkt_bits", pkt_bits, exp_bits);
                chk("pkt_len", PKT_W'(pkt_len_bits), PKT_W'(exp_len));
                held_bits = exp_bits; held_len = exp_len;
            end
            if (!eb) begin
                chk("hold_bits", pkt_bits, held_bits);
                chk("hold_len", PKT_W'(pkt_len_bits), PKT_W'(held_len));
            end
            if (start && !eb) begin
                pl.delete();
                if (pid == 4'b0010 || pid == 4'b1010 || pid == 4'b1110) begin
                    act = 1; s_cyc = cyc; L = 2; N = 0;
                    exp_bits = build_pkt(pid, pl, 0); exp_len = LEN_W'(16);
                end else if ((pid == 4'b0011 || pid == 4'b1011) && int'(occupancy) <= MAXB) begin
                    N = int'(occupancy);
                    for (int k = 0; k < N; k++) pl.push_back(buf_q[k]);
                    act = 1; s_cyc = cyc; L = (N == 0) ? 3 : N + 4;
                    exp_bits = build_pkt(pid, pl, 1); exp_len = LEN_W'(8 * (N + 4));
                end else begin
                    err_cyc = cyc + 1;
                end
            end
        end
    end

    longint start_cyc = 0;
    task automatic pulse_start(input logic [3:0] p, input int n);
        @(posedge clk); #1;
        pid = p; occupancy = OCC_W'(n); start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; pid = 4'($urandom); occupancy = OCC_W'($urandom);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 3000) begin @(posedge clk); #1; k++; end
        if (k >= 3000) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles, required 0", busy, k);
        end
        @(posedge clk); #1;
    endtask

    // mode 1: payload 0x31,0x32,...; otherwise random.
    task automatic req(input logic [3:0] p, input int n, input bit seq, input bit stray);
        if ((p == 4'b0011 || p == 4'b1011) && n <= MAXB)
            for (int i = 0; i < n; i++) buf_q.push_back(seq ? 8'(8'h31 + i) : 8'($urandom));
        pulse_start(p, n);
        if (stray && busy) begin
            repeat ($urandom_range(0, n)) begin @(posedge clk); #1; end
            if (busy) begin
                start = 1'b1; pid = 4'b0011; occupancy = OCC_W'($urandom_range(0, MAXB));
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        wait_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, e0;
        logic [PKT_W-1:0] saved;
        logic [3:0] pids[8];
        pids = '{4'b0010, 4'b1010, 4'b1110, 4'b0011, 4'b1011, 4'b0011, 4'b1011, 4'b0000};

        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        g0 = gets_total;
        req(4'b0010, 0, 0, 0);
        chk("ack_sync_pid", PKT_W'(pkt_bits[15:0]), PKT_W'(16'hD280));
        chk("ack_len", PKT_W'(pkt_len_bits), PKT_W'(16));
        chk("ack_no_get", PKT_W'(gets_total - g0), '0);
        chk("ack_latency", PKT_W'(ready_cyc - start_cyc), PKT_W'(2));

        g0 = gets_total;
        req(4'b0011, 9, 1, 0);
        chk("d0_payload", PKT_W'(pkt_bits[87:16]), PKT_W'(72'h393837363534333231));
        chk("d0_crc", PKT_W'(pkt_bits[103:88]), PKT_W'(16'hB4C8));
        chk("d0_len", PKT_W'(pkt_len_bits), PKT_W'(104));
        chk("d0_gets", PKT_W'(gets_total - g0), PKT_W'(9));
        chk("d0_latency", PKT_W'(ready_cyc - start_cyc), PKT_W'(13));

        req(4'b1011, 0, 0, 0);
        chk("d1_empty", PKT_W'(pkt_bits[31:8]), PKT_W'(24'h00004B));
        chk("d1_len", PKT_W'(pkt_len_bits), PKT_W'(32));
        chk("d1_latency", PKT_W'(ready_cyc - start_cyc), PKT_W'(3));

        g0 = gets_total;
        req(4'b0011, MAXB, 0, 0);
        chk("max_len", PKT_W'(pkt_len_bits), PKT_W'(544));
        chk("max_gets", PKT_W'(gets_total - g0), PKT_W'(MAXB));

        g0 = gets_total; e0 = err_total; saved = pkt_bits;
        req(4'b0011, MAXB + 1, 0, 0);
        chk("over_err", PKT_W'(err_total - e0), PKT_W'(1));
        chk("over_no_get", PKT_W'(gets_total - g0), '0);
        chk("over_retain", pkt_bits, saved);

        e0 = err_total;
        req(4'b0001, 3, 0, 0);
        chk("token_err", PKT_W'(err_total - e0), PKT_W'(1));

        req(4'b1011, 20, 0, 1);
        chk("buf_drained", PKT_W'(buf_q.size()), '0);

        // Abort mid-DATA after four pops.
        g0 = gets_total;
        for (int i = 0; i < 10; i++) buf_q.push_back(8'($urandom));
        pulse_start(4'b0011, 10);
        repeat (5) @(posedge clk); #1;
        chk("abort_gets", PKT_W'(gets_total - g0), PKT_W'(4));
        rst = 1'b1; #1;
        chk("abort_ctl", PKT_W'({busy, buf_get}), '0);
        chk("abort_bits", pkt_bits, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        buf_q.delete();
        @(posedge clk); #1;
        req(4'b0010, 0, 0, 0);
        chk("post_abort_ack", PKT_W'(pkt_bits[15:0]), PKT_W'(16'hD280));

        for (int it = 0; it < 40; it++) begin
            logic [3:0] p;
            int n;
            p = pids[$urandom_range(0, 7)];
            if (p == 4'b0000) p = 4'($urandom);
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(58, 70) : $urandom_range(0, 20);
            req(p, n, 0, 1'($urandom));
            chk("rand_drained", PKT_W'(buf_q.size()), '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
